// File: rtl/board_engine.sv
// board_engine: 2048 game-logic writer. Owns the committed 4x4 board read by the grid
// renderer; a move is processed one line per cycle and the result is committed atomically.
module board_engine #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          WIN_EXP = 11,
  parameter int          SCORE_W = 20
) (
  input  logic               dclk,
  input  logic               clr,
  input  logic               start,
  input  logic               load_valid,
  input  logic [63:0]        load_vals,
  input  logic               move_valid,
  input  logic [1:0]         move_dir,
  output logic               move_ready,
  output logic [63:0]        vals,
  output logic [SCORE_W-1:0] score,
  output logic               done,
  output logic               changed,
  output logic               win,
  output logic               game_over
);

  // LINE states are encoded 0..3 so the low state bits give the line number.
  typedef enum logic [2:0] {
    S_LINE0 = 3'd0, S_LINE1 = 3'd1, S_LINE2 = 3'd2, S_LINE3 = 3'd3,
    S_IDLE = 3'd4, S_SPAWN_A = 3'd5, S_SPAWN_B = 3'd6, S_CHECK = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q;
  logic [63:0]        wb_q, wb_d, vals_q, vals_d, wb_line;
  logic [SCORE_W-1:0] ws_q, ws_d, score_q, score_d;
  logic [1:0]         dir_q, dir_d, line_k;
  logic               done_q, done_d, changed_q, changed_d;
  logic               win_q, win_d, go_q, go_d;
  logic [15:0]        line_in, line_out;
  logic [17:0]        line_pts;

  function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] k,
                                          input logic [1:0] j);
    case (dir)
      2'd0:    return {k, j};
      2'd1:    return {k, ~j};
      2'd2:    return {j, k};
      default: return {~j, k};
    endcase
  endfunction

  function automatic logic [15:0] compress(input logic [15:0] in);
    logic [15:0] out;
    logic [2:0]  n;
    out = '0;
    n   = '0;
    for (int j = 0; j < 4; j++) begin
      if (in[4*j +: 4] != 4'd0) begin
        out[{n[1:0], 2'b00} +: 4] = in[4*j +: 4];
        n = n + 3'd1;
      end
    end
    return out;
  endfunction

  // Returns {points, line}. A merged pair leaves a zero behind, so no tile merges twice.
  function automatic logic [33:0] line_op(input logic [15:0] in);
    logic [15:0] c;
    logic [17:0] pts;
    c   = compress(in);
    pts = '0;
    for (int j = 0; j < 3; j++) begin
      if (c[4*j +: 4] != 4'd0 && c[4*j +: 4] != 4'hF && c[4*j +: 4] == c[4*j+4 +: 4]) begin
        pts = pts + (18'd1 << (c[4*j +: 4] + 4'd1));
        c[4*j +: 4]   = c[4*j +: 4] + 4'd1;
        c[4*j+4 +: 4] = 4'd0;
      end
    end
    return {pts, compress(c)};
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [17:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(b);
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  function automatic logic [63:0] spawn(input logic [63:0] b, input logic [15:0] r);
    logic [63:0] o;
    logic        found;
    logic [3:0]  idx;
    o     = b;
    found = 1'b0;
    for (int j = 0; j < 16; j++) begin
      idx = r[3:0] + 4'(j);
      if (!found && b[{idx, 2'b00} +: 4] == 4'd0) begin
        o[{idx, 2'b00} +: 4] = (r[7:4] == 4'd0) ? 4'd2 : 4'd1;
        found = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic logic has_win(input logic [63:0] b);
    logic w;
    w = 1'b0;
    for (int i = 0; i < 16; i++)
      if ({28'd0, b[4*i +: 4]} >= 32'(WIN_EXP)) w = 1'b1;
    return w;
  endfunction

  function automatic logic no_moves(input logic [63:0] b);
    logic stuck;
    stuck = 1'b1;
    for (int i = 0; i < 16; i++)
      if (b[4*i +: 4] == 4'd0) stuck = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (b[16*r+4*c +: 4] == b[16*r+4*c+4 +: 4]) stuck = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (b[16*r+4*c +: 4] == b[16*r+4*c+16 +: 4]) stuck = 1'b0;
    return stuck;
  endfunction

  assign line_k = state_q[1:0];

  always_comb begin
    line_in = '0;
    for (int j = 0; j < 4; j++)
      line_in[4*j +: 4] = wb_q[{cell_idx(dir_q, line_k, 2'(j)), 2'b00} +: 4];
    {line_pts, line_out} = line_op(line_in);
    wb_line = wb_q;
    for (int j = 0; j < 4; j++)
      wb_line[{cell_idx(dir_q, line_k, 2'(j)), 2'b00} +: 4] = line_out[4*j +: 4];
  end

  always_comb begin
    state_d   = state_q;
    wb_d      = wb_q;
    ws_d      = ws_q;
    dir_d     = dir_q;
    vals_d    = vals_q;
    score_d   = score_q;
    done_d    = 1'b0;
    changed_d = changed_q;
    win_d     = win_q;
    go_d      = go_q;
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          wb_d = load_vals; ws_d = '0; win_d = 1'b0; changed_d = 1'b0; state_d = S_CHECK;
        end else if (start) begin
          wb_d = '0; ws_d = '0; win_d = 1'b0; changed_d = 1'b0; state_d = S_SPAWN_A;
        end else if (move_valid) begin
          wb_d = vals_q; ws_d = score_q; dir_d = move_dir; changed_d = 1'b0; state_d = S_LINE0;
        end
      end
      S_LINE0, S_LINE1, S_LINE2: begin
        wb_d    = wb_line;
        ws_d    = sat_add(ws_q, line_pts);
        state_d = state_t'(state_q + 3'd1);
      end
      S_LINE3: begin
        wb_d = wb_line;
        ws_d = sat_add(ws_q, line_pts);
        if (wb_line != vals_q) begin
          changed_d = 1'b1;
          state_d   = S_SPAWN_B;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_SPAWN_A: begin
        wb_d    = spawn(wb_q, lfsr_q);
        state_d = S_SPAWN_B;
      end
      S_SPAWN_B: begin
        wb_d    = spawn(wb_q, lfsr_q);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        vals_d  = wb_q;
        score_d = ws_q;
        win_d   = win_q | has_win(wb_q);
        go_d    = no_moves(wb_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      vals_q    <= '0;
      score_q   <= '0;
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      win_q     <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      vals_q    <= vals_d;
      score_q   <= score_d;
      done_q    <= done_d;
      changed_q <= changed_d;
      win_q     <= win_d;
      go_q      <= go_d;
    end
  end

  // Working board is always initialised on command accept, so it needs no reset.
  always_ff @(posedge dclk) begin
    wb_q  <= wb_d;
    ws_q  <= ws_d;
    dir_q <= dir_d;
  end

  assign move_ready = (state_q == S_IDLE);
  assign vals       = vals_q;
  assign score      = score_q;
  assign done       = done_q;
  assign changed    = changed_q;
  assign win        = win_q;
  assign game_over  = go_q;

endmodule

// File: tb/tb_board_engine.sv
// Bench for board_engine: table of commands with hand expectations, plus a reference
// model feeding a scoreboard that is checked whenever done pulses.
module tb_board_engine;

  localparam int K_LOAD = 0, K_START = 1, K_MOVE = 2;
  localparam longint SMAX = (64'd1 << 20) - 1;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        dclk, clr, start, load_valid, move_valid;
  logic [63:0] load_vals, vals;
  logic [1:0]  move_dir;
  logic        move_ready, done, changed, win, game_over;
  logic [19:0] score;

  board_engine dut (
    .dclk(dclk), .clr(clr), .start(start), .load_valid(load_valid), .load_vals(load_vals),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready), .vals(vals),
    .score(score), .done(done), .changed(changed), .win(win), .game_over(game_over)
  );

  typedef struct {
    logic [63:0] v;
    longint      s;
    logic        chg, win, go;
    int          acc, lat;
  } exp_t;

  typedef struct {
    int          kind;
    logic [1:0]  dir;
    logic [63:0] lv;
    logic [63:0] hmask;
    logic [63:0] hval;
    int          hscore;
    logic        hchg, hwin, hgo;
  } vec_t;

  exp_t        q[$];
  int          total = 0, bad = 0, cyc = 0;
  logic [15:0] mlfsr;
  logic [63:0] mvals = '0;
  longint      mscore = 0;
  logic        mwin = 1'b0;

  initial begin
    dclk = 1'b0;
    forever #5 dclk = ~dclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(posedge dclk) cyc++;

  function automatic logic [15:0] nx(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  function automatic logic [15:0] nxn(input logic [15:0] x, input int n);
    for (int i = 0; i < n; i++) x = nx(x);
    return x;
  endfunction

  always @(posedge dclk or posedge clr)
    if (clr) mlfsr <= 16'hACE1;
    else     mlfsr <= nx(mlfsr);

  function automatic int cidx(input logic [1:0] d, input int k, input int j);
    case (d)
      2'd0:    return k*4 + j;
      2'd1:    return k*4 + 3 - j;
      2'd2:    return j*4 + k;
      default: return (3-j)*4 + k;
    endcase
  endfunction

  function automatic void mmove(input logic [63:0] b, input logic [1:0] d,
                                output logic [63:0] o, output int pts);
    int t[4];
    int u[4];
    int n, pend;
    o = b;
    pts = 0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) t[j] = int'(b[cidx(d, k, j)*4 +: 4]);
      u = '{0, 0, 0, 0};
      n = 0;
      pend = 0;
      for (int j = 0; j < 4; j++) begin
        if (t[j] != 0) begin
          if (t[j] == pend && pend != 15) begin
            u[n] = pend + 1; n++; pts += 1 << (pend + 1); pend = 0;
          end else begin
            if (pend != 0) begin u[n] = pend; n++; end
            pend = t[j];
          end
        end
      end
      if (pend != 0) begin u[n] = pend; n++; end
      for (int j = 0; j < 4; j++) o[cidx(d, k, j)*4 +: 4] = 4'(u[j]);
    end
  endfunction

  function automatic logic [63:0] mspawn(input logic [63:0] b, input logic [15:0] r);
    int s = int'(r[3:0]);
    int best = -1;
    int bd = 100;
    for (int i = 0; i < 16; i++) begin
      if (b[i*4 +: 4] == 4'd0) begin
        int dd = (i - s + 16) % 16;
        if (dd < bd) begin bd = dd; best = i; end
      end
    end
    if (best >= 0) b[best*4 +: 4] = (r[7:4] == 4'd0) ? 4'd2 : 4'd1;
    return b;
  endfunction

  function automatic logic mhaswin(input logic [63:0] b);
    for (int i = 0; i < 16; i++) if (b[i*4 +: 4] >= 4'd11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic tile_eq(input logic [63:0] b, input int a, input int c);
    return b[a*4 +: 4] == b[c*4 +: 4];
  endfunction

  function automatic logic mgameover(input logic [63:0] b);
    for (int i = 0; i < 16; i++) begin
      if (b[i*4 +: 4] == 4'd0) return 1'b0;
      if ((i % 4) != 3) begin if (tile_eq(b, i, i + 1)) return 1'b0; end
      if (i < 12) begin if (tile_eq(b, i, i + 4)) return 1'b0; end
    end
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge dclk) begin
    if (!clr && done) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending command");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_vals", vals, e.v);
        chk("sb_score", 64'(score), 64'(e.s));
        chk("sb_changed", 64'(changed), 64'(e.chg));
        chk("sb_win", 64'(win), 64'(e.win));
        chk("sb_game_over", 64'(game_over), 64'(e.go));
        chk("sb_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic cmd(input int kind, input logic [1:0] d, input logic [63:0] lv, input logic all3);
    exp_t e;
    logic [63:0] nb;
    int p, waitc;
    longint s;
    @(negedge dclk);
    e.acc = cyc + 1;
    p = 0;
    if (kind == K_LOAD || all3) begin
      e.v = lv; s = 0; mwin = 1'b0; e.chg = 1'b0; e.lat = 1;
    end else if (kind == K_START) begin
      e.v = mspawn(mspawn(64'd0, nx(mlfsr)), nxn(mlfsr, 2));
      s = 0; mwin = 1'b0; e.chg = 1'b0; e.lat = 3;
    end else begin
      mmove(mvals, d, nb, p);
      s = mscore + p;
      if (nb != mvals) begin
        e.v = mspawn(nb, nxn(mlfsr, 5)); e.chg = 1'b1; e.lat = 6;
      end else begin
        e.v = nb; e.chg = 1'b0; e.lat = 5;
      end
    end
    if (s > SMAX) s = SMAX;
    mwin   = mwin | mhaswin(e.v);
    e.win  = mwin;
    e.go   = mgameover(e.v);
    e.s    = s;
    mvals  = e.v;
    mscore = s;
    q.push_back(e);
    load_valid = (kind == K_LOAD) || all3;
    start      = (kind == K_START) || all3;
    move_valid = (kind == K_MOVE) || all3;
    move_dir   = d;
    load_vals  = lv;
    @(posedge dclk);
    @(negedge dclk);
    load_valid = 1'b0; start = 1'b0; move_valid = 1'b0;
    waitc = 0;
    while (q.size() != 0 && waitc < 40) begin
      @(negedge dclk);
      waitc++;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done within 40 cycles expected done");
      q.delete();
    end
  endtask

  initial begin
    vec_t tv[17];
    int cnt;
    logic okv;
    tv[0]  = '{K_LOAD, 2'd0, 64'h2211, ALL, 64'h2211, 0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{K_MOVE, 2'd0, 64'h0, 64'hFF, 64'h32, 12, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{K_LOAD, 2'd0, 64'h1111, ALL, 64'h1111, 0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{K_MOVE, 2'd1, 64'h0, 64'hFF00, 64'h2200, 8, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{K_LOAD, 2'd0, 64'h0000_0002_0002_0002, ALL, 64'h0000_0002_0002_0002, 0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{K_MOVE, 2'd2, 64'h0, 64'h0000_0000_000F_000F, 64'h0000_0000_0002_0003, 8, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{K_LOAD, 2'd0, 64'h0021, ALL, 64'h0021, 0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{K_MOVE, 2'd0, 64'h0, ALL, 64'h0021, 0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{K_LOAD, 2'd0, 64'h1212_2121_1212_2121, ALL, 64'h1212_2121_1212_2121, 0, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{K_MOVE, 2'd0, 64'h0, ALL, 64'h1212_2121_1212_2121, 0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{K_LOAD, 2'd0, 64'hB, ALL, 64'hB, 0, 1'b0, 1'b1, 1'b0};
    tv[11] = '{K_MOVE, 2'd1, 64'h0, 64'hF000, 64'hB000, 0, 1'b1, 1'b1, 1'b0};
    tv[12] = '{K_LOAD, 2'd0, 64'h00FF, ALL, 64'h00FF, 0, 1'b0, 1'b1, 1'b0};
    tv[13] = '{K_MOVE, 2'd0, 64'h0, ALL, 64'h00FF, 0, 1'b0, 1'b1, 1'b0};
    tv[14] = '{K_LOAD, 2'd0, 64'h0000_0010_0000_0010, ALL, 64'h0000_0010_0000_0010, 0, 1'b0, 1'b0, 1'b0};
    tv[15] = '{K_MOVE, 2'd3, 64'h0, 64'h00F0_0000_0000_0000, 64'h0020_0000_0000_0000, 4, 1'b1, 1'b0, 1'b0};
    tv[16] = '{K_START, 2'd0, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b0, 1'b0};

    clr = 1'b1; start = 1'b0; load_valid = 1'b0; move_valid = 1'b0;
    move_dir = 2'd0; load_vals = '0;
    #1;
    chk("rst_vals", vals, 64'd0);
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_move_ready", 64'(move_ready), 64'd1);
    chk("rst_win_go", {62'd0, win, game_over}, 64'd0);
    repeat (2) @(negedge dclk);
    clr = 1'b0;

    for (int i = 0; i < 17; i++) begin
      cmd(tv[i].kind, tv[i].dir, tv[i].lv, 1'b0);
      if (tv[i].hmask != 64'd0) chk($sformatf("hand_vals_%0d", i), vals & tv[i].hmask, tv[i].hval);
      chk($sformatf("hand_score_%0d", i), 64'(score), 64'(tv[i].hscore));
      chk($sformatf("hand_changed_%0d", i), 64'(changed), 64'(tv[i].hchg));
      chk($sformatf("hand_win_%0d", i), 64'(win), 64'(tv[i].hwin));
      chk($sformatf("hand_go_%0d", i), 64'(game_over), 64'(tv[i].hgo));
    end

    // After start: exactly two tiles, each holding exponent 1 or 2.
    cnt = 0;
    okv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (vals[i*4 +: 4] != 4'd0) begin
        cnt++;
        if (vals[i*4 +: 4] > 4'd2) okv = 1'b0;
      end
    end
    chk("start_tile_count", 64'(cnt), 64'd2);
    chk("start_tile_values", 64'(okv), 64'd1);

    // Simultaneous load, start and move: load must win.
    cmd(K_LOAD, 2'd1, 64'h0321, 1'b1);
    chk("prio_vals", vals, 64'h0321);

    // Reset in the middle of a move.
    cmd(K_LOAD, 2'd0, 64'h11BB, 1'b0);
    cmd(K_MOVE, 2'd0, 64'h0, 1'b0);
    chk("pre_rst_score", 64'(score), 64'd4100);
    @(negedge dclk);
    move_valid = 1'b1; move_dir = 2'd1;
    @(posedge dclk);
    @(negedge dclk);
    move_valid = 1'b0;
    @(posedge dclk);
    #2 clr = 1'b1;
    #1;
    chk("midrst_vals", vals, 64'd0);
    chk("midrst_score", 64'(score), 64'd0);
    chk("midrst_done_changed", {62'd0, done, changed}, 64'd0);
    chk("midrst_win_go", {62'd0, win, game_over}, 64'd0);
    chk("midrst_move_ready", 64'(move_ready), 64'd1);
    mvals = '0; mscore = 0; mwin = 1'b0;
    @(negedge dclk);
    clr = 1'b0;
    @(posedge dclk);
    #1;
    chk("postrst_vals", vals, 64'd0);
    chk("postrst_done", 64'(done), 64'd0);
    chk("postrst_move_ready", 64'(move_ready), 64'd1);
    repeat (8) @(negedge dclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
